sfq_toggle_rx: RTL
==================

Name: sfq_toggle_rx

Overview:
Clocked readout stage that sits directly downstream of a clocked RSFQ gate output, such as a two-input OR cell's q. In that output, every transition (rising or falling) encodes one SFQ pulse. The block synchronises the toggle line into the digital clk domain, turns transitions into pulse events and reduces them to one bit per SFQ clock epoch (marked by `epoch`). It then deserialises those bits, LSB first, into words delivered over a valid/ready handshake, and flags protocol violations.

Parameters:
WORD_W, 8, bits per output word (2..32)
CNT_W, 16, width of the free-running pulse counter
SYNC_STAGES, 2, synchroniser flop count on q_in (2..4)

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
q_in  input  1  toggle-encoded SFQ line (asynchronous to clk)
en  input  1  high = epochs processed and pulses counted
epoch  input  1  one-cycle strobe closing the current SFQ clock epoch
err_clr  input  1  clears the sticky error flags
word_data  output  WORD_W  deserialised word, bit0 = oldest epoch
word_valid  output  1  word_data holds an unconsumed word
word_ready  input  1  consumer accepts word this cycle when high with word_valid
pulse_cnt  output  CNT_W  total pulses detected while en=1
multi_err  output  1  sticky: an epoch contained 2 or more pulses
ovf_err  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (rst=1 at a clk edge):
  - Clears sync chain, history flop, pulse accumulator, bit index, shift register, word_data, word_valid, pulse_cnt, multi_err and ovf_err, all to 0.
  - Loads a guard counter with SYNC_STAGES+1.
  - Reset mid-word discards the partial word and any held word.
- Synchroniser: q_in passes through SYNC_STAGES flops; the output is sync_q. The history flop hist <= sync_q every cycle.
- Pulse detection: pulse_det = (sync_q ^ hist) && guard==0. The guard decrements to 0 after reset, which masks spurious edges from q_in reset level. A q_in change is therefore seen as pulse_det SYNC_STAGES+1 cycles later.
- Epoch accumulator: 2-bit saturating count of pulse_det since the last accepted epoch.
  - A pulse_det in the same cycle as epoch belongs to the epoch being closed.
- On epoch && en:
  - bit = (acc+pulse_det) >= 1.
  - multi_err is set if (acc+pulse_det) >= 2; the bit is still 1.
  - acc clears; bit is written to shift[bit_idx]; bit_idx increments.
- Word completion: on the epoch with bit_idx == WORD_W-1, bit_idx wraps to 0 and the word is complete.
  - If !word_valid, or word_valid && word_ready in the same cycle: word_data <= word and word_valid <= 1.
  - Otherwise the word is dropped, ovf_err is set, and held word_data is unchanged.
- Handshake:
  - word_valid and word_data stay stable until a cycle with word_ready=1.
  - word_valid falls the cycle after acceptance, unless a new word loads in that same cycle.
  - word_ready with word_valid=0 has no effect.
- en=0:
  - epoch is ignored (bit_idx and shift hold) and pulses are not counted.
  - acc is held at 0.
  - sync_q and hist keep tracking, so re-enabling produces no false pulse.
- pulse_cnt: increments by 1 per pulse_det while en=1 and wraps modulo 2^CNT_W.
- err_clr: clears both sticky flags. A new error in the same cycle wins (the flag remains 1).
- Word output latency: word_valid rises the cycle after the WORD_W-th accepted epoch.

Decomposition:
- Package sfq_rx_pkg holds:
  - default WORD_W, CNT_W and SYNC_STAGES constants;
  - the 2-bit saturating accumulator type;
  - the error-flag index constants (ERR_MULTI=0, ERR_OVF=1).
- Sub-module sfq_toggle_sync contains the synchroniser, history flop, guard counter and pulse_det output. The top level holds the accumulator, deserialiser, output register and counters.

Test Plan:
- Reset release with q_in=1 held, then no toggles for 20 cycles -> pulse_cnt=0, no epoch bit set, multi_err=0.
- Single-pulse mapping: one toggle per epoch for epochs 0,2,3,7 (WORD_W=8), word_ready=1 -> word_data=0x8D and word_valid high for one cycle; pulse_cnt=4.
- Two toggles within one epoch -> bit=1 and multi_err=1. Then err_clr -> multi_err=0. err_clr coincident with a new double pulse -> multi_err stays 1.
- Backpressure: word_ready=0, two full words (0xFF then 0x01) -> first word held as 0xFF, second dropped, ovf_err=1. Completion in the same cycle as word_ready=1 -> new word loads with no gap and ovf_err unchanged.
- Edge cases: en=0 for 3 epochs with toggles -> bit_idx and pulse_cnt unchanged. Toggle landing exactly on the epoch cycle -> counted in the closing epoch. CNT_W=4 with 17 pulses -> pulse_cnt=1.
- rst asserted after 5 of 8 epochs with word_valid=1 -> all outputs 0. The next 8 epochs produce a fresh, correctly aligned word.

Source files
------------

// File: rtl/sfq_rx_pkg.sv
package sfq_rx_pkg;

  localparam int unsigned WORD_W_DEF      = 8;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  localparam int unsigned ERR_MULTI = 0;
  localparam int unsigned ERR_OVF   = 1;

  typedef logic [1:0] acc_t;

  function automatic acc_t acc_add(acc_t a, logic inc);
    if (inc && (a != '1)) return a + acc_t'(1);
    return a;
  endfunction

endpackage

// File: rtl/sfq_toggle_sync.sv
module sfq_toggle_sync
  import sfq_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic q_in,
  output logic pulse_det
);

  localparam int unsigned GUARD_W = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   hist_q;
  logic [GUARD_W-1:0]     guard_q;
  logic                   sync_q;

  assign sync_q = chain_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      hist_q  <= 1'b0;
      guard_q <= GUARD_W'(SYNC_STAGES + 1);
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], q_in};
      hist_q  <= sync_q;
      if (guard_q != '0) guard_q <= guard_q - GUARD_W'(1);
    end
  end

  // Guard masks the edge produced when the cleared chain catches up with q_in's level.
  always_comb begin
    pulse_det = (sync_q ^ hist_q) && (guard_q == '0);
  end

endmodule

// File: rtl/sfq_toggle_rx.sv
module sfq_toggle_rx
  import sfq_rx_pkg::*;
#(
  parameter int unsigned WORD_W      = WORD_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_in,
  input  logic              en,
  input  logic              epoch,
  input  logic              err_clr,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [CNT_W-1:0]  pulse_cnt,
  output logic              multi_err,
  output logic              ovf_err
);

  localparam int unsigned IDX_W = $clog2(WORD_W);

  logic              pulse_det;
  acc_t              acc_q, acc_d, sum;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic              take, bit_v, done, load;

  sfq_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .q_in     (q_in),
    .pulse_det(pulse_det)
  );

  always_comb begin
    take    = epoch && en;
    sum     = acc_add(acc_q, pulse_det);
    bit_v   = (sum != '0);
    done    = take && (idx_q == IDX_W'(WORD_W - 1));
    load    = done && (!valid_q || word_ready);

    shift_d = shift_q;
    if (take) shift_d[idx_q] = bit_v;

    acc_d = (!en || take) ? acc_t'(0) : sum;

    idx_d = idx_q;
    if (take) idx_d = done ? '0 : idx_q + IDX_W'(1);

    data_d  = load ? shift_d : data_q;
    valid_d = valid_q;
    if (load) valid_d = 1'b1;
    else if (valid_q && word_ready) valid_d = 1'b0;

    cnt_d = (en && pulse_det) ? cnt_q + CNT_W'(1) : cnt_q;

    // Clear first so an error raised in the same cycle survives err_clr.
    err_d = err_clr ? 2'b00 : err_q;
    if (take && (sum >= acc_t'(2))) err_d[ERR_MULTI] = 1'b1;
    if (done && !load) err_d[ERR_OVF] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign word_data  = data_q;
  assign word_valid = valid_q;
  assign pulse_cnt  = cnt_q;
  assign multi_err  = err_q[ERR_MULTI];
  assign ovf_err    = err_q[ERR_OVF];

endmodule
